// File: rtl/axi4s_dp_pkg.sv
//------------------------------------------------------------------------------
// Module      : axi4s_dp_pkg
// Description : Shared AXI4-Stream datapath word carried between OSF stages.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package axi4s_dp_pkg;

    typedef struct packed {
        logic        tvalid;
        logic [63:0] tdata;
        logic [7:0]  tuser;
        logic [7:0]  tid;
        logic [7:0]  tstrb;
        logic        tlast;
    } axi4s_dp_bus_t;

endpackage

`default_nettype wire

// File: rtl/cr_osfPKG.sv
//------------------------------------------------------------------------------
// Module      : cr_osfPKG
// Description : OSF outbound framing types and TLV marker codes.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package cr_osfPKG;

    typedef enum logic [0:0] {
        OSF_OB_IDLE = 1'b0,
        OSF_OB_FRM  = 1'b1
    } osf_ob_frm_st_e;

    // Marker codes in tuser, also used by the latency-insertion stage
    localparam logic [7:0] OSF_OB_SOT = 8'h1;
    localparam logic [7:0] OSF_OB_EOT = 8'h2;

endpackage

`default_nettype wire

// File: rtl/cr_osf_ob_fifo.sv
//------------------------------------------------------------------------------
// Module      : cr_osf_ob_fifo
// Description : Small circular register FIFO of axi4s_dp_bus_t words.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module cr_osf_ob_fifo
    import axi4s_dp_pkg::*;
#(
    parameter int DEPTH = 2,
    localparam int OCC_W = $clog2(DEPTH + 1)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            push,
    input  axi4s_dp_bus_t   push_data,
    input  logic            pop,
    output axi4s_dp_bus_t   head,
    output logic [OCC_W-1:0] occupancy,
    output logic            full,
    output logic            empty
);

    localparam int PTR_W = $clog2(DEPTH);

    axi4s_dp_bus_t    r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [OCC_W-1:0] r_occ;
    logic             w_push;
    logic             w_pop;

    function automatic logic [PTR_W-1:0] f_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign full      = (r_occ == OCC_W'(DEPTH));
    assign empty     = (r_occ == '0);
    assign w_push    = push & ~full;
    assign w_pop     = pop & ~empty;
    assign head      = r_mem[r_rd_ptr];
    assign occupancy = r_occ;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_occ    <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else begin
            if (w_push) begin
                r_mem[r_wr_ptr] <= push_data;
                r_wr_ptr        <= f_inc(r_wr_ptr);
            end
            if (w_pop) begin
                r_rd_ptr <= f_inc(r_rd_ptr);
            end
            case ({w_push, w_pop})
                2'b10:   r_occ <= r_occ + 1'b1;
                2'b01:   r_occ <= r_occ - 1'b1;
                default: r_occ <= r_occ;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: rtl/cr_osf_ob_mstr.sv
//------------------------------------------------------------------------------
// Module      : cr_osf_ob_mstr
// Description : OSF outbound AXI4-Stream master: pops the upstream FIFO,
//               buffers words, checks TLV framing and keeps statistics.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module cr_osf_ob_mstr
    import axi4s_dp_pkg::*;
    import cr_osfPKG::*;
#(
    parameter int DEPTH = 2,
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  axi4s_dp_bus_t    axi4s_in,
    input  logic             axi4s_in_avail,
    output logic             axi4s_mstr_rd,
    output axi4s_dp_bus_t    axi4s_ob_out,
    input  logic             axi4s_ob_tready,
    output logic             ob_frm_done,
    output logic             ob_proto_err,
    output logic [CNT_W-1:0] ob_frm_cnt,
    output logic [CNT_W-1:0] ob_stall_cnt
);

    localparam int OCC_W = $clog2(DEPTH + 1);

    axi4s_dp_bus_t    w_push_word;
    axi4s_dp_bus_t    w_head;
    logic [OCC_W-1:0] w_occ;
    logic             w_full;
    logic             w_empty;
    logic             w_tvalid;
    logic             w_accept;
    logic             w_sot;
    logic             w_eot;

    osf_ob_frm_st_e   r_state;
    osf_ob_frm_st_e   w_state_nxt;
    logic             w_done_nxt;
    logic             w_err_nxt;
    logic             r_frm_done;
    logic             r_proto_err;
    logic [CNT_W-1:0] r_frm_cnt;
    logic [CNT_W-1:0] r_stall_cnt;

    // Pop decision depends only on registered occupancy, never on tready
    assign axi4s_mstr_rd = ~rst & axi4s_in_avail & (w_occ < OCC_W'(DEPTH));

    always_comb begin
        w_push_word        = axi4s_in;
        w_push_word.tvalid = 1'b1;
    end

    cr_osf_ob_fifo #(
        .DEPTH     (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (axi4s_mstr_rd),
        .push_data (w_push_word),
        .pop       (w_accept),
        .head      (w_head),
        .occupancy (w_occ),
        .full      (w_full),
        .empty     (w_empty)
    );

    assign w_tvalid = w_head.tvalid & ~w_empty;
    assign w_accept = w_tvalid & axi4s_ob_tready;
    assign w_sot    = (w_head.tuser == OSF_OB_SOT);
    assign w_eot    = (w_head.tuser == OSF_OB_EOT);

    always_comb begin
        axi4s_ob_out        = w_head;
        axi4s_ob_out.tvalid = w_tvalid;
    end

    always_comb begin
        w_state_nxt = r_state;
        w_done_nxt  = 1'b0;
        w_err_nxt   = 1'b0;
        if (w_accept) begin
            case (r_state)
                OSF_OB_IDLE: begin
                    if (!w_sot) begin
                        w_err_nxt = 1'b1;
                    end else if (w_head.tlast) begin
                        w_done_nxt = 1'b1;
                    end else begin
                        w_state_nxt = OSF_OB_FRM;
                    end
                end
                OSF_OB_FRM: begin
                    // A stray SOT restarts the frame rather than aborting it
                    if (w_sot) begin
                        w_err_nxt = 1'b1;
                    end else if (w_eot && w_head.tlast) begin
                        w_done_nxt  = 1'b1;
                        w_state_nxt = OSF_OB_IDLE;
                    end else if (w_eot) begin
                        w_err_nxt = 1'b1;
                    end
                end
                default: w_state_nxt = OSF_OB_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= OSF_OB_IDLE;
            r_frm_done  <= 1'b0;
            r_proto_err <= 1'b0;
            r_frm_cnt   <= '0;
            r_stall_cnt <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_frm_done  <= w_done_nxt;
            r_proto_err <= w_err_nxt;
            if (w_done_nxt) begin
                r_frm_cnt <= r_frm_cnt + 1'b1;
            end
            if (w_tvalid && !axi4s_ob_tready && !(&r_stall_cnt)) begin
                r_stall_cnt <= r_stall_cnt + 1'b1;
            end
        end
    end

    assign ob_frm_done  = r_frm_done;
    assign ob_proto_err = r_proto_err;
    assign ob_frm_cnt   = r_frm_cnt;
    assign ob_stall_cnt = r_stall_cnt;

endmodule

`default_nettype wire

// File: tb/tb_cr_osf_ob_mstr.sv
//------------------------------------------------------------------------------
// Module      : tb_cr_osf_ob_mstr
// Description : Self-checking bench for cr_osf_ob_mstr (default build plus a
//               narrow-counter, deeper-buffer build for counter boundaries).
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_cr_osf_ob_mstr;
    import axi4s_dp_pkg::*;

    localparam int A_DEPTH = 2;

    typedef struct {
        int load;
        int rst;
        int rdy;
        int e_rd;
        int e_v;
        int e_done;
        int e_err;
    } vec_t;

    logic          clk;
    logic          rst;
    axi4s_dp_bus_t in_w;
    logic          avail;
    logic          rd;
    axi4s_dp_bus_t out_w;
    logic          tready;
    logic          done;
    logic          perr;
    logic [31:0]   frm_cnt;
    logic [31:0]   stall_cnt;

    axi4s_dp_bus_t b_in;
    logic          b_avail;
    logic          b_rd;
    axi4s_dp_bus_t b_out;
    logic          b_rdy;
    logic          b_done;
    logic          b_err;
    logic [3:0]    b_frm;
    logic [3:0]    b_stall;

    int checks;
    int errors;

    axi4s_dp_bus_t src[$];
    axi4s_dp_bus_t expq[$];
    vec_t          tbl[$];
    int            m_st;
    logic          m_done;
    logic          m_err;
    logic [31:0]   m_frm;
    logic [31:0]   m_stall;

    cr_osf_ob_mstr #(.DEPTH(A_DEPTH), .CNT_W(32)) dut (
        .clk             (clk),
        .rst             (rst),
        .axi4s_in        (in_w),
        .axi4s_in_avail  (avail),
        .axi4s_mstr_rd   (rd),
        .axi4s_ob_out    (out_w),
        .axi4s_ob_tready (tready),
        .ob_frm_done     (done),
        .ob_proto_err    (perr),
        .ob_frm_cnt      (frm_cnt),
        .ob_stall_cnt    (stall_cnt)
    );

    cr_osf_ob_mstr #(.DEPTH(4), .CNT_W(4)) dut_b (
        .clk             (clk),
        .rst             (rst),
        .axi4s_in        (b_in),
        .axi4s_in_avail  (b_avail),
        .axi4s_mstr_rd   (b_rd),
        .axi4s_ob_out    (b_out),
        .axi4s_ob_tready (b_rdy),
        .ob_frm_done     (b_done),
        .ob_proto_err    (b_err),
        .ob_frm_cnt      (b_frm),
        .ob_stall_cnt    (b_stall)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: run did not finish, got timeout required completion");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h required %0h", name, act, exp);
        end
    endtask

    function automatic axi4s_dp_bus_t mkw(input logic [63:0] d, input logic [7:0] u, input logic l);
        axi4s_dp_bus_t w;
        logic [7:0]    lo;
        lo       = d[7:0];
        w        = '0;
        w.tdata  = d;
        w.tuser  = u;
        w.tlast  = l;
        w.tid    = lo ^ 8'h5A;
        w.tstrb  = ~lo;
        w.tvalid = 1'b0;
        return w;
    endfunction

    function automatic vec_t mkv(input int ld, input int r, input int rdy, input int e_rd,
                                 input int e_v, input int e_done, input int e_err);
        vec_t v;
        v.load = ld; v.rst = r; v.rdy = rdy; v.e_rd = e_rd;
        v.e_v = e_v; v.e_done = e_done; v.e_err = e_err;
        return v;
    endfunction

    task automatic load_set(input int k);
        src.delete();
        case (k)
            1: begin
                src.push_back(mkw(64'h01, 8'h1, 1'b0));
                src.push_back(mkw(64'h02, 8'h0, 1'b0));
                src.push_back(mkw(64'h03, 8'h0, 1'b0));
                src.push_back(mkw(64'h04, 8'h2, 1'b1));
            end
            2: begin
                src.push_back(mkw(64'h10, 8'h1, 1'b0));
                for (int i = 1; i < 5; i++) src.push_back(mkw(64'h10 + 64'(i), 8'h0, 1'b0));
                src.push_back(mkw(64'h15, 8'h2, 1'b1));
            end
            3: begin
                src.push_back(mkw(64'h20, 8'h0, 1'b0));
                src.push_back(mkw(64'h21, 8'h1, 1'b0));
                src.push_back(mkw(64'h22, 8'h1, 1'b0));
                src.push_back(mkw(64'h23, 8'h2, 1'b0));
                src.push_back(mkw(64'h24, 8'h2, 1'b1));
            end
            4: begin
                src.push_back(mkw(64'h30, 8'h1, 1'b0));
                for (int i = 1; i < 4; i++) src.push_back(mkw(64'h30 + 64'(i), 8'h0, 1'b0));
                src.push_back(mkw(64'h34, 8'h2, 1'b1));
            end
            default: begin
                src.push_back(mkw(64'h40, 8'h1, 1'b0));
                src.push_back(mkw(64'h41, 8'h0, 1'b0));
                src.push_back(mkw(64'h42, 8'h2, 1'b1));
            end
        endcase
    endtask

    task automatic run_row(input vec_t r, input int idx);
        axi4s_dp_bus_t w;
        logic          e_rd;
        logic          e_v;
        logic          nd;
        logic          ne;
        @(negedge clk);
        if (r.load != 0) load_set(r.load);
        rst    = (r.rst != 0);
        tready = (r.rdy != 0);
        avail  = (src.size() > 0);
        in_w   = avail ? src[0] : '0;
        #1;
        e_rd = (r.rst == 0) && avail && (expq.size() < A_DEPTH);
        e_v  = (expq.size() != 0);
        chk($sformatf("row%0d mstr_rd", idx), 64'(rd), 64'(r.e_rd));
        chk($sformatf("row%0d tvalid", idx), 64'(out_w.tvalid), 64'(r.e_v));
        chk($sformatf("row%0d frm_done", idx), 64'(done), 64'(r.e_done));
        chk($sformatf("row%0d proto_err", idx), 64'(perr), 64'(r.e_err));
        chk($sformatf("row%0d frm_cnt", idx), 64'(frm_cnt), 64'(m_frm));
        chk($sformatf("row%0d stall_cnt", idx), 64'(stall_cnt), 64'(m_stall));
        if (e_v) begin
            chk($sformatf("row%0d tdata", idx), out_w.tdata, expq[0].tdata);
            chk($sformatf("row%0d sideband", idx),
                64'({out_w.tuser, out_w.tid, out_w.tstrb, out_w.tlast}),
                64'({expq[0].tuser, expq[0].tid, expq[0].tstrb, expq[0].tlast}));
        end
        if (r.rst != 0) begin
            expq.delete();
            m_st = 0; m_done = 1'b0; m_err = 1'b0; m_frm = '0; m_stall = '0;
        end else begin
            nd = 1'b0;
            ne = 1'b0;
            if (e_v && r.rdy != 0) begin
                w = expq.pop_front();
                if (m_st == 0) begin
                    if (w.tuser != 8'h01) ne = 1'b1;
                    else if (!w.tlast) m_st = 1;
                    else nd = 1'b1;
                end else begin
                    if (w.tuser == 8'h01) ne = 1'b1;
                    else if (w.tuser == 8'h02 && w.tlast) begin nd = 1'b1; m_st = 0; end
                    else if (w.tuser == 8'h02) ne = 1'b1;
                end
            end
            if (e_v && r.rdy == 0 && m_stall != 32'hFFFF_FFFF) m_stall = m_stall + 1;
            m_done = nd;
            m_err  = ne;
            if (nd) m_frm = m_frm + 1;
            if (e_rd) begin
                w = src.pop_front();
                w.tvalid = 1'b1;
                expq.push_back(w);
            end
        end
    endtask

    initial begin
        checks = 0; errors = 0;
        m_st = 0; m_done = 1'b0; m_err = 1'b0; m_frm = '0; m_stall = '0;
        rst = 1'b1; tready = 1'b1; avail = 1'b0; in_w = '0;
        b_avail = 1'b0; b_rdy = 1'b1; b_in = '0;

        // idle after reset
        tbl.push_back(mkv(0, 0, 1, 0, 0, 0, 0));
        // streaming 4-beat frame
        tbl.push_back(mkv(1, 0, 1, 1, 0, 0, 0));
        tbl.push_back(mkv(0, 0, 1, 1, 1, 0, 0));
        tbl.push_back(mkv(0, 0, 1, 1, 1, 0, 0));
        tbl.push_back(mkv(0, 0, 1, 1, 1, 0, 0));
        tbl.push_back(mkv(0, 0, 1, 0, 1, 0, 0));
        tbl.push_back(mkv(0, 0, 1, 0, 0, 1, 0));
        // backpressure 5 cycles, then full with tready in the same cycle
        tbl.push_back(mkv(2, 0, 0, 1, 0, 0, 0));
        tbl.push_back(mkv(0, 0, 0, 1, 1, 0, 0));
        for (int i = 0; i < 3; i++) tbl.push_back(mkv(0, 0, 0, 0, 1, 0, 0));
        tbl.push_back(mkv(0, 0, 1, 0, 1, 0, 0));
        for (int i = 0; i < 4; i++) tbl.push_back(mkv(0, 0, 1, 1, 1, 0, 0));
        tbl.push_back(mkv(0, 0, 1, 0, 1, 0, 0));
        tbl.push_back(mkv(0, 0, 1, 0, 0, 1, 0));
        // protocol errors: non-SOT in idle, SOT in frame, EOT without tlast
        tbl.push_back(mkv(3, 0, 1, 1, 0, 0, 0));
        tbl.push_back(mkv(0, 0, 1, 1, 1, 0, 0));
        tbl.push_back(mkv(0, 0, 1, 1, 1, 0, 1));
        tbl.push_back(mkv(0, 0, 1, 1, 1, 0, 0));
        tbl.push_back(mkv(0, 0, 1, 1, 1, 0, 1));
        tbl.push_back(mkv(0, 0, 1, 0, 1, 0, 1));
        tbl.push_back(mkv(0, 0, 1, 0, 0, 1, 0));
        // reset mid-frame with two words buffered, then a clean frame
        tbl.push_back(mkv(4, 0, 0, 1, 0, 0, 0));
        tbl.push_back(mkv(0, 0, 0, 1, 1, 0, 0));
        tbl.push_back(mkv(0, 1, 0, 0, 1, 0, 0));
        tbl.push_back(mkv(0, 1, 0, 0, 0, 0, 0));
        tbl.push_back(mkv(5, 0, 1, 1, 0, 0, 0));
        tbl.push_back(mkv(0, 0, 1, 1, 1, 0, 0));
        tbl.push_back(mkv(0, 0, 1, 1, 1, 0, 0));
        tbl.push_back(mkv(0, 0, 1, 0, 1, 0, 0));
        tbl.push_back(mkv(0, 0, 1, 0, 0, 1, 0));

        repeat (2) @(posedge clk);
        for (int i = 0; i < tbl.size(); i++) run_row(tbl[i], i);
        chk("reset_frame_cnt", 64'(frm_cnt), 64'd1);

        // narrow counters: frame count wraps from 15 to 0
        for (int k = 0; k < 21; k++) begin
            @(negedge clk);
            b_avail = 1'b1;
            b_rdy   = 1'b1;
            b_in    = mkw(64'h100 + 64'(k), 8'h1, 1'b1);
            #1;
            chk($sformatf("b%0d mstr_rd", k), 64'(b_rd), 64'd1);
            chk($sformatf("b%0d frm_cnt", k), 64'(b_frm), (k >= 2) ? 64'((k - 1) % 16) : 64'd0);
            chk($sformatf("b%0d frm_done", k), 64'(b_done), 64'(k >= 2));
            chk($sformatf("b%0d proto_err", k), 64'(b_err), 64'd0);
        end
        // stall counter saturates at all-ones; buffer of 4 fills then stops popping
        for (int j = 0; j < 22; j++) begin
            @(negedge clk);
            b_rdy = 1'b0;
            #1;
            chk($sformatf("bs%0d stall_cnt", j), 64'(b_stall), 64'((j < 15) ? j : 15));
            chk($sformatf("bs%0d mstr_rd", j), 64'(b_rd), 64'(j < 3));
            chk($sformatf("bs%0d frm_cnt", j), 64'(b_frm), 64'd4);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
